// File: rtl/y_pkg.sv
// Shared opcode, state and constant definitions for the iterative multiply/divide unit.
// Latency: none (definitions only).
// Backpressure: not applicable.
package y_pkg;

  // funct3 encodings of the M-extension operations
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Most negative two's-complement value of a w-bit word, returned in 64 bits
  function automatic logic [63:0] MIN_SIGNED(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/y_muldiv_step.sv
// One iteration of shift-add multiply (mode=0) or restoring divide (mode=1) on {hi,lo}.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module y_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply: add multiplicand when lo[0] set, then shift {carry,hi,lo} right.
  // Divide: shift {rem,quot} left, trial-subtract divisor at WIDTH+1 bits, restore on borrow.
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    rem_s = {hi, lo[WIDTH-1]};
    ge    = (rem_s >= {1'b0, operand});
    // When ge holds the true difference is below 2^WIDTH, so the low bits are exact
    diff  = rem_s[WIDTH-1:0] - operand;
    if (!mode) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end else if (ge) begin
      hi_n = diff;
      lo_n = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = rem_s[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/y_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit with start/ready issue and done pulse.
// Latency: done in cycle WIDTH+2 after the accepting edge, cycle 1 for divide special cases.
// Backpressure: ready low while busy; start is ignored (not queued) until ready returns.
module y_muldiv
  import y_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_S    = WIDTH'(MIN_SIGNED(WIDTH));

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, z_q, z_d;
  logic             done_q, done_d, ready_q, ready_d;

  logic             a_sgn, b_sgn, b_zero, ovf;
  logic [WIDTH-1:0] a_abs, b_abs, step_hi, step_lo, res;
  logic [2*WIDTH-1:0] prod, prod_f;

  y_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode    (op_q[2]),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (opnd_q),
    .hi_n    (step_hi),
    .lo_n    (step_lo)
  );

  // Issue-time operand conditioning: signedness per op, magnitudes, special-case detection
  always_comb begin
    a_sgn  = a[WIDTH-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    b_sgn  = b[WIDTH-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
    a_abs  = a_sgn ? -a : a;
    b_abs  = b_sgn ? -b : b;
    b_zero = (b == '0);
    ovf    = (a == MIN_S) && (b == '1);
  end

  // Sign fix-up and result selection from the finished {hi,lo} register
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_f = neg_q ? -prod : prod;
    case (op_q)
      OP_MUL:                      res = prod_f[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod_f[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             res = neg_q ? -lo_q : lo_q;
      default:                     res = neg_q ? -hi_q : hi_q;
    endcase
  end

  // Next-state logic for the IDLE/CALC/FIX/DONE sequencer and its datapath registers
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    z_d     = z_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && ready_q) begin
          op_d    = op;
          cnt_d   = CNT_INIT;
          hi_d    = '0;
          ready_d = 1'b0;
          // Remainder takes the dividend sign; quotient and product take the xor
          neg_d   = (op[2] && op[1]) ? a_sgn : (a_sgn ^ b_sgn);
          if (op[2]) begin
            lo_d   = a_abs;
            opnd_d = b_abs;
          end else begin
            lo_d   = b_abs;
            opnd_d = a_abs;
          end
          if (op[2] && b_zero) begin
            z_d     = op[1] ? a : '1;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if ((op == OP_DIV || op == OP_REM) && ovf) begin
            z_d     = op[1] ? '0 : a;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hi_d = step_hi;
        lo_d = step_lo;
        // Counter holds at 1 on the last iteration so it never wraps
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        z_d     = res;
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      z_q     <= z_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign busy  = ~ready_q;
  assign done  = done_q;
  assign z     = z_q;

endmodule
